// File: rtl/rv_pkg.sv
// Shared constants and helpers for the 4-way ready/valid arbiter.
package rv_pkg;

   localparam int num_req    = 4;
   localparam int id_w       = 2;
   localparam int wd_default = 4;

   // Decode a requester index into a one-hot requester mask.
   function automatic logic [num_req-1:0] idx_to_oh(input logic [id_w-1:0] idx);
      logic [num_req-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rv_arb_sel.sv
// Priority select: picks the first valid requester starting at ptr and
// wrapping modulo num_req. A ptr tied to zero gives fixed 0 > 1 > 2 > 3 order.
module rv_arb_sel
   import rv_pkg::*;
(
   input  logic [num_req-1:0] val,
   input  logic [id_w-1:0]    ptr,
   output logic [num_req-1:0] grant_oh,
   output logic [id_w-1:0]    grant_idx,
   output logic               grant_any
);

   logic [id_w-1:0] cand;

   // Walk the requesters in priority order; the first valid one wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 0; k < num_req; k++) begin
         cand = ptr + id_w'(k);
         if (!grant_any && val[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      grant_oh = grant_any ? idx_to_oh(grant_idx) : '0;
   end

endmodule

// File: rtl/rv_arb4.sv
// Four-requester ready/valid arbiter with a single registered output slot.
// Define RV_ARB_RR_EN for round-robin priority; otherwise requester 0 always
// has the highest priority.
module rv_arb4
   import rv_pkg::*;
#(
   parameter int wd = wd_default
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [num_req*wd-1:0] datain,
   input  logic [num_req-1:0]    datain_val,
   output logic [num_req-1:0]    datain_rdy,
   output logic [wd-1:0]         dataout,
   output logic                  dataout_val,
   input  logic                  dataout_rdy,
   output logic [id_w-1:0]       dataout_id
);

   logic [num_req-1:0] grant_oh;
   logic [id_w-1:0]    grant_idx;
   logic               grant_any;
   logic [id_w-1:0]    sel_ptr;
   logic               slot_free;
   logic               accept;
   logic [wd-1:0]      word_sel;

`ifdef RV_ARB_RR_EN
   logic [id_w-1:0] ptr;

   // Pointer moves just past the most recent winner so it gets lowest priority next.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= grant_idx + id_w'(1);
      end
   end

   assign sel_ptr = ptr;
`else
   assign sel_ptr = '0;
`endif

   rv_arb_sel u_sel (
      .val       (datain_val),
      .ptr       (sel_ptr),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // The slot can take a new word when empty or when being drained this cycle.
   assign slot_free  = ~dataout_val | dataout_rdy;
   assign datain_rdy = (rst || !slot_free || !grant_any) ? '0 : grant_oh;
   assign accept     = |datain_rdy;
   assign word_sel   = datain[int'(grant_idx)*wd +: wd];

   // Output slot: load on accept, clear valid on a drain with no refill, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataout     <= '0;
         dataout_id  <= '0;
         dataout_val <= 1'b0;
      end else if (accept) begin
         dataout     <= word_sel;
         dataout_id  <= grant_idx;
         dataout_val <= 1'b1;
      end else if (dataout_val && dataout_rdy) begin
         dataout_val <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_arb4.sv
module tb_rv_arb4;

   localparam int wd = 4;

   logic            clk;
   logic            rst;
   logic [4*wd-1:0] datain;
   logic [3:0]      datain_val;
   logic [3:0]      datain_rdy;
   logic [wd-1:0]   dataout;
   logic            dataout_val;
   logic            dataout_rdy;
   logic [1:0]      dataout_id;

   logic [wd-1:0] w [4];
   int checks;
   int failures;

   assign datain = {w[3], w[2], w[1], w[0]};

   rv_arb4 #(.wd(wd)) dut (
      .clk         (clk),
      .rst         (rst),
      .datain      (datain),
      .datain_val  (datain_val),
      .datain_rdy  (datain_rdy),
      .dataout     (dataout),
      .dataout_val (dataout_val),
      .dataout_rdy (dataout_rdy),
      .dataout_id  (dataout_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      datain_val = 4'b1111;
      dataout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) w[i] = wd'(i + 1);
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (datain_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rdy cyc%0d got=%b exp=0000", c, datain_rdy);
         end
         checks++;
         if (dataout_val !== 1'b0) begin
            failures++;
            $display("FAIL reset_val cyc%0d got=%b exp=0", c, dataout_val);
         end
         checks++;
         if (dataout !== 4'd0) begin
            failures++;
            $display("FAIL reset_data cyc%0d got=%0d exp=0", c, dataout);
         end
         checks++;
         if (dataout_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_id cyc%0d got=%0d exp=0", c, dataout_id);
         end
      end
   endtask

   task automatic test_single();
      rst = 1'b0;
      datain_val = 4'b0100;
      w[2] = 4'd5;
      dataout_rdy = 1'b1;
      #1;
      checks++;
      if (datain_rdy !== 4'b0100) begin
         failures++;
         $display("FAIL single_rdy got=%b exp=0100", datain_rdy);
      end
      tick();
      datain_val = 4'b0000;
      checks++;
      if (dataout !== 4'd5 || dataout_id !== 2'd2 || dataout_val !== 1'b1) begin
         failures++;
         $display("FAIL single_out got=%0d/%0d/%b exp=5/2/1", dataout, dataout_id, dataout_val);
      end
   endtask

   task automatic test_backpressure();
      dataout_rdy = 1'b0;
      datain_val = 4'b0001;
      w[0] = 4'd9;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (datain_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL bp_rdy cyc%0d got=%b exp=0000", c, datain_rdy);
         end
         tick();
         checks++;
         if (dataout !== 4'd5 || dataout_id !== 2'd2 || dataout_val !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold cyc%0d got=%0d/%0d/%b exp=5/2/1", c, dataout, dataout_id, dataout_val);
         end
      end
      dataout_rdy = 1'b1;
      #1;
      checks++;
      if (datain_rdy !== 4'b0001) begin
         failures++;
         $display("FAIL bp_release_rdy got=%b exp=0001", datain_rdy);
      end
      tick();
      checks++;
      if (dataout !== 4'd9 || dataout_id !== 2'd0 || dataout_val !== 1'b1) begin
         failures++;
         $display("FAIL bp_nobubble got=%0d/%0d/%b exp=9/0/1", dataout, dataout_id, dataout_val);
      end
      datain_val = 4'b0000;
      #1;
      checks++;
      if (datain_rdy !== 4'b0000) begin
         failures++;
         $display("FAIL idle_rdy got=%b exp=0000", datain_rdy);
      end
      tick();
      checks++;
      if (dataout_val !== 1'b0 || dataout !== 4'd9 || dataout_id !== 2'd0) begin
         failures++;
         $display("FAIL drain got=%0d/%0d/%b exp=9/0/0", dataout, dataout_id, dataout_val);
      end
   endtask

   task automatic test_priority();
      logic [1:0] exp_id [5];
`ifdef RV_ARB_RR_EN
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      rst = 1'b1;
      datain_val = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) w[i] = wd'(4'hA + i);
      datain_val = 4'b1111;
      dataout_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         logic [3:0] exp_rdy;
         logic [3:0] exp_word;
         exp_rdy = 4'b0001 << exp_id[c];
         exp_word = 4'hA + 4'(exp_id[c]);
         #1;
         checks++;
         if (datain_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL prio_rdy cyc%0d got=%b exp=%b", c, datain_rdy, exp_rdy);
         end
         tick();
         checks++;
         if (dataout_id !== exp_id[c] || dataout !== exp_word || dataout_val !== 1'b1) begin
            failures++;
            $display("FAIL prio_out cyc%0d got=%0d/%0d/%b exp=%0d/%0d/1",
                     c, dataout_id, dataout, dataout_val, exp_id[c], exp_word);
         end
      end
   endtask

   task automatic test_midop_reset();
      datain_val = 4'b0010;
      w[1] = 4'd15;
      dataout_rdy = 1'b1;
      tick();
      datain_val = 4'b0000;
      dataout_rdy = 1'b0;
      tick();
      checks++;
      if (dataout !== 4'd15 || dataout_id !== 2'd1 || dataout_val !== 1'b1) begin
         failures++;
         $display("FAIL midrst_held got=%0d/%0d/%b exp=15/1/1", dataout, dataout_id, dataout_val);
      end
      rst = 1'b1;
      datain_val = 4'b1111;
      #1;
      checks++;
      if (datain_rdy !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_rdy got=%b exp=0000", datain_rdy);
      end
      tick();
      checks++;
      if (dataout_val !== 1'b0 || dataout !== 4'd0 || dataout_id !== 2'd0) begin
         failures++;
         $display("FAIL midrst_clear got=%0d/%0d/%b exp=0/0/0", dataout, dataout_id, dataout_val);
      end
      rst = 1'b0;
      dataout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) w[i] = wd'(i + 3);
      #1;
      checks++;
      if (datain_rdy !== 4'b0001) begin
         failures++;
         $display("FAIL midrst_first_rdy got=%b exp=0001", datain_rdy);
      end
      tick();
      checks++;
      if (dataout_id !== 2'd0 || dataout !== 4'd3 || dataout_val !== 1'b1) begin
         failures++;
         $display("FAIL midrst_first_out got=%0d/%0d/%b exp=0/3/1", dataout_id, dataout, dataout_val);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      datain_val = 4'b0000;
      dataout_rdy = 1'b0;
      for (int i = 0; i < 4; i++) w[i] = '0;
      #2;
      test_reset();
      test_single();
      test_backpressure();
      test_priority();
      test_midop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
